// File: rtl/prio_encoder_seq.sv
// rtl/prio_encoder_seq.sv - registered N-input priority encoder with request latching and valid/ready output
//
// Request pulses are latched into a pending register. Each time the output
// stage is free or being accepted, one eligible pending request is moved
// into the output stage and presented as a binary index. Selection is either
// fixed (highest index wins) or round-robin (last grant gets lowest priority).
//
// Parameters:
//   N      number of request inputs (N >= 2)
//   IDX_W  width of out_idx, derived from N; leave at its default
//   RR     0 = fixed priority, highest index wins; 1 = round-robin
//
// Ports:
//   clk          clock, all state changes on the rising edge
//   rst          synchronous reset, active-high
//   req          request pulses; a high bit sets the matching pending bit
//   mask         1 = request ineligible for grant, pending bit retained
//   out_idx      index of the granted request in the output stage
//   out_valid    out_idx holds a granted request
//   out_ready    consumer accepts out_idx when out_valid & out_ready
//   pending      current pending register
//   any_pending  OR-reduction of pending
//   overflow     sticky lost-duplicate-request flag
//
// Build option:
//   PRIO_ENCODER_SEQ_OVERFLOW_EN  when defined, overflow sets whenever a
//   request arrives for a bit that is already pending and not granted in
//   that cycle, and stays set until rst. When undefined, overflow is 0.

module prio_encoder_seq #(
    parameter int N     = 8,
    parameter int IDX_W = $clog2(N),
    parameter bit RR    = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic [N-1:0]     mask,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     pending,
    output logic             any_pending,
    output logic             overflow
);

    logic [N-1:0]     pending_q, pending_d;
    logic             out_valid_q, out_valid_d;
    logic [IDX_W-1:0] out_idx_q, out_idx_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;

    logic [N-1:0]     eligible;
    logic [N-1:0]     clear_onehot;
    logic [IDX_W-1:0] winner;
    logic             found;
    logic             load;
    logic [IDX_W-1:0] cand_idx;
    int               cand;

    assign eligible = pending_q & ~mask;

    // Winner selection. Fixed mode scans upward so the highest set index is
    // the last to write winner. Round-robin walks ptr-1, ptr-2, ... wrapping
    // through N-1 and ending at ptr, so the previous grant ranks last.
    always_comb begin
        winner   = '0;
        found    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        if (RR) begin
            for (int i = 1; i <= N; i++) begin
                cand = int'(ptr_q) + N - i;
                if (cand >= N) begin
                    cand = cand - N;
                end
                cand_idx = IDX_W'(cand);
                if (!found && eligible[cand_idx]) begin
                    winner = cand_idx;
                    found  = 1'b1;
                end
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                cand_idx = IDX_W'(i);
                if (eligible[cand_idx]) begin
                    winner = cand_idx;
                    found  = 1'b1;
                end
            end
        end
    end

    // The output stage can take a new grant when it is empty or its current
    // contents are being accepted this cycle.
    assign load = (!out_valid_q || out_ready) && (|eligible);

    always_comb begin
        clear_onehot = '0;
        if (load) begin
            clear_onehot = {{(N-1){1'b0}}, 1'b1} << winner;
        end
    end

    always_comb begin
        // A request arriving for the bit being granted re-sets it.
        pending_d   = (pending_q & ~clear_onehot) | req;
        out_valid_d = out_valid_q;
        out_idx_d   = out_idx_q;
        ptr_d       = ptr_q;
        if (load) begin
            out_valid_d = 1'b1;
            out_idx_d   = winner;
            ptr_d       = winner;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q   <= '0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            ptr_q       <= '0;
        end else begin
            pending_q   <= pending_d;
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
            ptr_q       <= ptr_d;
        end
    end

`ifdef PRIO_ENCODER_SEQ_OVERFLOW_EN
    logic overflow_q, overflow_d;

    // A duplicate is lost when the bit is already pending and is not being
    // moved to the output stage in the same cycle.
    always_comb begin
        overflow_d = overflow_q | (|(req & pending_q & ~clear_onehot));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign overflow = overflow_q;
`else
    assign overflow = 1'b0;
`endif

    assign out_idx     = out_idx_q;
    assign out_valid   = out_valid_q;
    assign pending     = pending_q;
    assign any_pending = |pending_q;

endmodule

// File: tb/tb_prio_encoder_seq.sv
// tb/tb_prio_encoder_seq.sv - self-checking bench for prio_encoder_seq, fixed and round-robin instances

module tb_prio_encoder_seq;

`ifdef PRIO_ENCODER_SEQ_OVERFLOW_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic [7:0] mask;
    logic       out_ready;

    logic [2:0] idx0, idx1;
    logic       v0, v1;
    logic [7:0] pend0, pend1;
    logic       any0, any1;
    logic       ovf0, ovf1;

    always #5 clk = ~clk;

    prio_encoder_seq #(.N(8), .RR(1'b0)) dut_fix (
        .clk(clk), .rst(rst), .req(req), .mask(mask),
        .out_idx(idx0), .out_valid(v0), .out_ready(out_ready),
        .pending(pend0), .any_pending(any0), .overflow(ovf0)
    );

    prio_encoder_seq #(.N(8), .RR(1'b1)) dut_rr (
        .clk(clk), .rst(rst), .req(req), .mask(mask),
        .out_idx(idx1), .out_valid(v1), .out_ready(out_ready),
        .pending(pend1), .any_pending(any1), .overflow(ovf1)
    );

    typedef struct {
        logic       rst;
        logic [7:0] req;
        logic [7:0] mask;
        logic       rdy;
        logic       valid;
        logic [2:0] idx;
        logic [7:0] pend;
    } vec_t;

    vec_t tbl[26];

    int tests = 0;
    int fails = 0;

    logic [2:0] sb0[$];
    logic [2:0] sb1[$];
    bit         sb_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic [7:0] rq, input logic [7:0] mk_,
                                input logic rd, input logic vl, input logic [2:0] ix,
                                input logic [7:0] pd);
        vec_t v;
        v.rst = r; v.req = rq; v.mask = mk_; v.rdy = rd;
        v.valid = vl; v.idx = ix; v.pend = pd;
        return v;
    endfunction

    // Handshakes are judged on the values visible before the edge; the
    // accepted index is compared against the next queued expectation.
    task automatic step();
        logic [2:0] e;
        if (sb_en) begin
            if (v0 && out_ready) begin
                if (sb0.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL sb_fix_extra: got grant %0d expected none", idx0);
                end else begin
                    e = sb0.pop_front();
                    check("sb_fix_grant", 32'(idx0), 32'(e));
                end
            end
            if (v1 && out_ready) begin
                if (sb1.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL sb_rr_extra: got grant %0d expected none", idx1);
                end else begin
                    e = sb1.pop_front();
                    check("sb_rr_grant", 32'(idx1), 32'(e));
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cycles;

        rst = 1'b1; req = '0; mask = '0; out_ready = 1'b1;

        //               rst  req     mask   rdy  valid idx   pend
        tbl[0]  = mk(1'b1, 8'h00, 8'h00, 1'b1, 1'b0, 3'd0, 8'h00);
        tbl[1]  = mk(1'b0, 8'h01, 8'h00, 1'b1, 1'b0, 3'd0, 8'h01);
        tbl[2]  = mk(1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 3'd0, 8'h00);
        tbl[3]  = mk(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 3'd0, 8'h00);
        tbl[4]  = mk(1'b0, 8'hA4, 8'h00, 1'b1, 1'b0, 3'd0, 8'hA4);
        tbl[5]  = mk(1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 3'd7, 8'h24);
        tbl[6]  = mk(1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 3'd5, 8'h04);
        tbl[7]  = mk(1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 3'd2, 8'h00);
        tbl[8]  = mk(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 3'd2, 8'h00);
        tbl[9]  = mk(1'b0, 8'hA4, 8'h00, 1'b0, 1'b0, 3'd2, 8'hA4);
        tbl[10] = mk(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 3'd7, 8'h24);
        tbl[11] = mk(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 3'd7, 8'h24);
        tbl[12] = mk(1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 3'd5, 8'h04);
        tbl[13] = mk(1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 3'd2, 8'h00);
        tbl[14] = mk(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 3'd2, 8'h00);
        tbl[15] = mk(1'b0, 8'h82, 8'h80, 1'b1, 1'b0, 3'd2, 8'h82);
        tbl[16] = mk(1'b0, 8'h00, 8'h80, 1'b1, 1'b1, 3'd1, 8'h80);
        tbl[17] = mk(1'b0, 8'h00, 8'h80, 1'b1, 1'b0, 3'd1, 8'h80);
        tbl[18] = mk(1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 3'd7, 8'h00);
        tbl[19] = mk(1'b0, 8'h0C, 8'h00, 1'b0, 1'b1, 3'd7, 8'h0C);
        tbl[20] = mk(1'b1, 8'h0C, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00);
        tbl[21] = mk(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 3'd0, 8'h00);
        tbl[22] = mk(1'b0, 8'h10, 8'h00, 1'b1, 1'b0, 3'd0, 8'h10);
        tbl[23] = mk(1'b0, 8'h10, 8'h00, 1'b1, 1'b1, 3'd4, 8'h10);
        tbl[24] = mk(1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 3'd4, 8'h00);
        tbl[25] = mk(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 3'd4, 8'h00);

        // Both instances agree on every row: no row offers a choice where
        // round-robin order differs from fixed order.
        for (int i = 0; i < 26; i++) begin
            rst = tbl[i].rst; req = tbl[i].req; mask = tbl[i].mask; out_ready = tbl[i].rdy;
            step();
            check($sformatf("fix_valid[%0d]", i), 32'(v0),    32'(tbl[i].valid));
            check($sformatf("fix_idx[%0d]", i),   32'(idx0),  32'(tbl[i].idx));
            check($sformatf("fix_pend[%0d]", i),  32'(pend0), 32'(tbl[i].pend));
            check($sformatf("fix_any[%0d]", i),   32'(any0),  32'(tbl[i].pend != 8'h00));
            check($sformatf("fix_ovf[%0d]", i),   32'(ovf0),  32'(0));
            check($sformatf("rr_valid[%0d]", i),  32'(v1),    32'(tbl[i].valid));
            check($sformatf("rr_idx[%0d]", i),    32'(idx1),  32'(tbl[i].idx));
            check($sformatf("rr_pend[%0d]", i),   32'(pend1), 32'(tbl[i].pend));
        end

        // Saturating requests: one grant per cycle, fixed always 7,
        // round-robin rotates downward and wraps.
        rst = 1'b1; req = '0; mask = '0; out_ready = 1'b1;
        step();
        rst = 1'b0; req = 8'hFF;
        for (int k = 0; k < 10; k++) begin
            sb0.push_back(3'd7);
            sb1.push_back(3'(7 - (k % 8)));
        end
        sb_en = 1'b1;
        cycles = 0;
        while ((sb0.size() != 0 || sb1.size() != 0) && cycles < 40) begin
            step();
            cycles++;
        end
        sb_en = 1'b0;
        check("ff_drained", 32'(sb0.size() + sb1.size()), 32'(0));
        check("ff_cycles", 32'(cycles), 32'(12));
        check("ff_ovf_fix", 32'(ovf0), 32'(OVF_EN));
        check("ff_ovf_rr", 32'(ovf1), 32'(OVF_EN));
        req = '0; rst = 1'b1;
        step();
        check("ff_ovf_reset", 32'(ovf0), 32'(0));
        check("ff_valid_reset", 32'(v1), 32'(0));

        // Lost duplicate: park 7 in the output stage, then re-request 3
        // while it sits pending.
        rst = 1'b0; out_ready = 1'b0; req = 8'h80;
        step();
        req = 8'h00; step();
        check("ov_hold_idx", 32'(idx0), 32'(7));
        req = 8'h08; step();
        req = 8'h00; step();
        check("ov_pend3", 32'(pend0), 32'(8'h08));
        check("ov_before", 32'(ovf0), 32'(0));
        req = 8'h08; step();
        req = 8'h00; step();
        check("ov_after_fix", 32'(ovf0), 32'(OVF_EN));
        check("ov_after_rr", 32'(ovf1), 32'(OVF_EN));
        req = 8'h08; step();
        req = 8'h00;
        out_ready = 1'b1;
        sb0.push_back(3'd7); sb0.push_back(3'd3);
        sb1.push_back(3'd7); sb1.push_back(3'd3);
        sb_en = 1'b1;
        step();
        step();
        sb_en = 1'b0;
        check("ov_drained", 32'(sb0.size() + sb1.size()), 32'(0));
        check("ov_valid_end", 32'(v0), 32'(0));
        check("ov_pend_end", 32'(pend0), 32'(0));
        check("ov_sticky", 32'(ovf0), 32'(OVF_EN));
        rst = 1'b1; step();
        check("ov_cleared", 32'(ovf0), 32'(0));
        check("ov_cleared_rr", 32'(ovf1), 32'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/prio_encoder_seq.md
Name: prio_encoder_seq

Overview:
- Parametrised, registered N-input priority encoder with request latching and a valid/ready output.
- Request pulses are captured into a pending register.
- One pending request is granted per handshake and presented as a binary index.
- Fixed-priority or round-robin selection. Sits between interrupt/event sources and a single consumer.

Parameters:
- N, 8, number of request inputs (N >= 2).
- IDX_W, $clog2(N), width of the output index (derived; do not override).
- RR, 0, 0 = fixed priority with the highest index winning; 1 = round-robin.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  synchronous reset, active-high.
- req  input  N  request bits. Each cycle a bit is high sets the corresponding pending bit.
- mask  input  N  1 = request ineligible for grant; its pending bit is retained.
- out_idx  output  IDX_W  granted request index.
- out_valid  output  1  out_idx holds a granted request.
- out_ready  input  1  consumer accepts out_idx when out_valid & out_ready.
- pending  output  N  current pending register.
- any_pending  output  1  OR-reduction of pending.
- overflow  output  1  sticky request-overflow flag (see Optional Feature).

Behaviour:
- Reset values (rst high at a clock edge): pending=0, out_valid=0, out_idx=0, RR pointer=0, overflow=0. req is ignored in the reset cycle. Reset mid-operation drops any presented and pending requests without a handshake.
- Eligible vector: eligible = pending & ~mask.
- Load condition: load = (!out_valid | out_ready) & |eligible.
- On load:
  - out_idx <= winner and out_valid <= 1.
  - pending[winner] is cleared in the same edge.
- out_valid falls to 0 when out_valid & out_ready and no eligible bit exists.
- Backpressure: when out_valid & !out_ready, out_idx and out_valid hold stable and no new load occurs.
- Pending update: pending_next = (pending & ~clear_onehot) | req.
  - If req[k] is high in the same cycle that k is granted, req wins and pending[k] stays set.
- Latency: a req pulse at edge t sets pending at t+1 and out_valid at t+2 (output stage idle, bit unmasked).
- Throughput: one grant per cycle while out_ready is held high.
- Fixed mode (RR=0): the winner is the highest set index of eligible.
- Round-robin mode (RR=1):
  - After granting k, the pointer becomes k.
  - The next search order is k-1, k-2, …, 0, N-1, …, k, so k has the lowest priority.
  - Pointer reset value 0 makes the first search order N-1 down to 0, identical to fixed mode.
- Masked bits: stay pending indefinitely and become eligible the cycle after mask drops.
- A bit already in the output stage is no longer pending. It cannot be granted twice unless it is re-requested.
- out_idx holds its last value while out_valid=0.

Optional Feature:
- Macro: PRIO_ENCODER_SEQ_OVERFLOW_EN.
- Defined: overflow is set when req[k]=1 while pending[k]=1 and k is not granted that cycle (a lost duplicate request).
  - overflow is sticky until rst.
  - overflow rises the edge after the offending cycle.
- Not defined: overflow is tied to 0 and no detection logic is built.

Test Plan:
- Parameters N=8, RR=0 unless stated.
- Release rst; pulse req=8'h01 one cycle with out_ready=1 -> out_valid=1, out_idx=0 two edges later; out_valid=0 on the next edge; pending=0.
- Pulse req=8'b1010_0100, out_ready=1 -> out_idx 7, 5, 2 on consecutive cycles, then out_valid=0; any_pending falls after the third grant is loaded.
- Same pulse with out_ready=0 -> out_idx=7 held stable, pending=8'b0010_0100; raise out_ready -> 7 accepted, then 5 and 2 follow.
- mask=8'h80, pulse req=8'b1000_0010 -> grant 1 only, pending=8'h80; clear mask -> grant 7 one cycle later. Assert rst mid-stream -> out_valid=0 and pending=0 on the next edge.
- Hold req=8'hFF, out_ready=1:
  - RR=0 -> out_idx=7 every cycle.
  - RR=1 -> 7, 6, 5, 4, 3, 2, 1, 0, 7 repeating.
- With PRIO_ENCODER_SEQ_OVERFLOW_EN and out_ready=0, pulse req[3] twice on non-consecutive cycles after pending[3] is set -> overflow=1, staying set through subsequent grants until rst. Without the macro, overflow=0 throughout.
